// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer arithmetic for the synchronous FIFO.
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_L      = 3;

    // Advance a ring pointer of arbitrary (non power-of-two) depth.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// L x DATA_W register array with one write port and one registered read port.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int L      = DEFAULT_L,
    localparam int ADD_W = $clog2(L)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADD_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADD_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [L];

    // NOTE: the array is deliberately left out of reset; the read register is
    // reset instead, and only written entries are ever read, so stale contents stay hidden.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO: pointer, occupancy and flag control around sync_fifo_mem.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int L      = DEFAULT_L
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int ADD_W = $clog2(L);
    localparam int CNT_W = $clog2(L + 1);

    logic [ADD_W-1:0] wp;
    logic [ADD_W-1:0] rp;
    logic [CNT_W-1:0] cnt;
    logic             wr_ok;
    logic             rd_ok;

    // Flags come straight off the registered count, so they track each edge with no lag.
    assign full  = (cnt == CNT_W'(L));
    assign empty = (cnt == '0);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr_ok) begin
                wp <= ADD_W'(ptr_inc(32'(wp), L));
            end
            if (rd_ok) begin
                rp <= ADD_W'(ptr_inc(32'(rp), L));
            end
            if (wr_ok && !rd_ok) begin
                cnt <= cnt + CNT_W'(1);
            end else if (rd_ok && !wr_ok) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .L      (L)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wp),
        .wdata (din),
        .re    (rd_ok),
        .raddr (rp),
        .rdata (dout)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus a randomized scoreboard run.
module tb_sync_fifo;

    localparam int DATA_W = 8;
    localparam int L      = 3;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;

    int n_pass;
    int n_total;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] exp_dout;

    sync_fifo #(
        .DATA_W (DATA_W),
        .L      (L)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, update the scoreboard, sample 1 ns after the edge.
    task automatic step(input logic wr, input logic rd, input logic [DATA_W-1:0] d);
        bit w_ok;
        bit r_ok;
        w_ok  = wr && (q.size() < L);
        r_ok  = rd && (q.size() > 0);
        wr_en = wr;
        rd_en = rd;
        din   = d;
        @(posedge clk);
        if (r_ok) exp_dout = q.pop_front();
        if (w_ok) q.push_back(d);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        q.delete(); exp_dout = '0;
        #1;
        n_total++;
        if ({full, empty, dout} !== {1'b0, 1'b1, 8'd0})
            $display("FAIL reset: got full=%0b empty=%0b dout=%0d, want 0 1 0", full, empty, dout);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if ({full, empty, dout} !== {1'b0, 1'b1, 8'd0})
            $display("FAIL reset_release: got full=%0b empty=%0b dout=%0d, want 0 1 0", full, empty, dout);
        else n_pass++;
    endtask

    task automatic test_fill();
        logic [DATA_W-1:0] data [3] = '{8'd3, 8'd4, 8'd5};
        logic              efull[3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, data[i]);
            n_total++;
            if ({full, empty, dout} !== {efull[i], 1'b0, 8'd0})
                $display("FAIL fill_%0d: got full=%0b empty=%0b dout=%0d, want %0b 0 0",
                         i, full, empty, dout, efull[i]);
            else n_pass++;
        end
        n_total++;
        if (dut.cnt !== 2'd3) $display("FAIL fill_cnt: got %0d, want 3", dut.cnt);
        else n_pass++;
    endtask

    task automatic test_write_full();
        step(1'b1, 1'b0, 8'd9);
        n_total++;
        if ({full, empty, dout} !== {1'b1, 1'b0, 8'd0})
            $display("FAIL write_full: got full=%0b empty=%0b dout=%0d, want 1 0 0", full, empty, dout);
        else n_pass++;
    endtask

    task automatic test_drain();
        logic [DATA_W-1:0] edout[4] = '{8'd3, 8'd4, 8'd5, 8'd5};
        logic              eempty[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'd0);
            n_total++;
            if ({full, empty, dout} !== {1'b0, eempty[i], edout[i]})
                $display("FAIL drain_%0d: got full=%0b empty=%0b dout=%0d, want 0 %0b %0d",
                         i, full, empty, dout, eempty[i], edout[i]);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b0, 8'd6);
        step(1'b1, 1'b0, 8'd7);
        step(1'b0, 1'b1, 8'd0);
        n_total++;
        if ({empty, dout} !== {1'b0, 8'd6})
            $display("FAIL wrap_rd0: got empty=%0b dout=%0d, want 0 6", empty, dout);
        else n_pass++;
        step(1'b0, 1'b1, 8'd0);
        n_total++;
        if ({empty, dout} !== {1'b1, 8'd7})
            $display("FAIL wrap_rd1: got empty=%0b dout=%0d, want 1 7", empty, dout);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        step(1'b1, 1'b0, 8'd10);
        step(1'b1, 1'b1, 8'd11);
        n_total++;
        if ({full, empty, dout, dut.cnt} !== {1'b0, 1'b0, 8'd10, 2'd1})
            $display("FAIL simul_both: got full=%0b empty=%0b dout=%0d cnt=%0d, want 0 0 10 1",
                     full, empty, dout, dut.cnt);
        else n_pass++;
        step(1'b0, 1'b1, 8'd0);
        n_total++;
        if ({empty, dout} !== {1'b1, 8'd11})
            $display("FAIL simul_next: got empty=%0b dout=%0d, want 1 11", empty, dout);
        else n_pass++;
    endtask

    task automatic test_empty_edges();
        step(1'b0, 1'b1, 8'd0);
        n_total++;
        if ({empty, dout} !== {1'b1, 8'd11})
            $display("FAIL rd_empty: got empty=%0b dout=%0d, want 1 11", empty, dout);
        else n_pass++;
        step(1'b1, 1'b1, 8'd12);
        n_total++;
        if ({empty, dout} !== {1'b0, 8'd11})
            $display("FAIL both_empty: got empty=%0b dout=%0d, want 0 11", empty, dout);
        else n_pass++;
        step(1'b0, 1'b1, 8'd0);
        n_total++;
        if ({empty, dout} !== {1'b1, 8'd12})
            $display("FAIL both_empty_rd: got empty=%0b dout=%0d, want 1 12", empty, dout);
        else n_pass++;
    endtask

    task automatic test_full_both();
        logic [DATA_W-1:0] edout[3] = '{8'd20, 8'd21, 8'd22};
        logic              eempty[3] = '{1'b0, 1'b0, 1'b1};
        step(1'b1, 1'b0, 8'd20);
        step(1'b1, 1'b0, 8'd21);
        step(1'b1, 1'b0, 8'd22);
        n_total++;
        if (full !== 1'b1) $display("FAIL full_both_pre: got full=%0b, want 1", full);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(1'b1 && (i == 0), 1'b1, 8'd23);
            n_total++;
            if ({full, empty, dout} !== {1'b0, eempty[i], edout[i]})
                $display("FAIL full_both_%0d: got full=%0b empty=%0b dout=%0d, want 0 %0b %0d",
                         i, full, empty, dout, eempty[i], edout[i]);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 8'd30);
        step(1'b1, 1'b0, 8'd31);
        wr_en = 1'b0;
        #2;
        rst = 1'b0;
        q.delete();
        exp_dout = '0;
        #1;
        n_total++;
        if ({full, empty, dout} !== {1'b0, 1'b1, 8'd0})
            $display("FAIL async_reset: got full=%0b empty=%0b dout=%0d, want 0 1 0", full, empty, dout);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'd40);
        step(1'b0, 1'b1, 8'd0);
        n_total++;
        if ({empty, dout} !== {1'b1, 8'd40})
            $display("FAIL after_reset: got empty=%0b dout=%0d, want 1 40", empty, dout);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic              w;
        logic              r;
        logic [DATA_W-1:0] d;
        for (int i = 0; i < 300; i++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = DATA_W'($urandom);
            step(w, r, d);
            n_total++;
            if ({full, empty, dout} !== {q.size() == L, q.size() == 0, exp_dout})
                $display("FAIL b2b_%0d: got full=%0b empty=%0b dout=%0d, want %0b %0b %0d",
                         i, full, empty, dout, q.size() == L, q.size() == 0, exp_dout);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_fill();
        test_write_full();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_empty_edges();
        test_full_both();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
